// File: rtl/cache_mem_arbiter.sv
// Merges icache/dcache sram-like ports onto one in-order memory bus.
// Optional `ARB_RR_EN selects round-robin arbitration instead of D-first priority.
module cache_mem_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [1:0]        i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;

  // Owner bit per outstanding transaction: 0 = I, 1 = D
  logic [OUTSTANDING-1:0] owner_q;
  logic [PW-1:0]          wptr_q;
  logic [PW-1:0]          rptr_q;
  logic [CW-1:0]          count_q;
  logic                   lock_q;
  logic                   lock_own_q;

  logic gnt_v;
  logic gnt;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head;

`ifdef ARB_RR_EN
  // Master preferred on the next contended cycle
  logic rr_q;
`endif

  always_comb begin
    gnt_v = i_req | d_req;
    gnt   = d_req;
    if (lock_q) begin
      gnt_v = 1'b1;
      gnt   = lock_own_q;
    end else if (i_req & d_req) begin
`ifdef ARB_RR_EN
      gnt = rr_q;
`else
      gnt = 1'b1;
`endif
    end
  end

  assign full  = count_q == CW'(OUTSTANDING);
  assign empty = count_q == '0;
  assign head  = owner_q[rptr_q];

  assign m_req   = gnt_v & (gnt ? d_req : i_req) & ~full;
  assign m_wr    = gnt_v & (gnt ? d_wr : i_wr);
  assign m_size  = !gnt_v ? '0 : (gnt ? d_size : i_size);
  assign m_addr  = !gnt_v ? '0 : (gnt ? d_addr : i_addr);
  assign m_wdata = !gnt_v ? '0 : (gnt ? d_wdata : i_wdata);

  assign push = m_req & m_addr_ok;
  assign pop  = m_data_ok & ~empty;

  assign i_addr_ok = push & ~gnt;
  assign d_addr_ok = push & gnt;
  assign i_data_ok = pop & ~head;
  assign d_data_ok = pop & head;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_own_q <= 1'b0;
      err        <= 1'b0;
`ifdef ARB_RR_EN
      rr_q       <= 1'b1;
`endif
    end else begin
      if (push) begin
        owner_q[wptr_q] <= gnt;
        wptr_q          <= wptr_q + 1'b1;
      end
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push) begin
        lock_q <= 1'b0;
      end else if (m_req) begin
        lock_q     <= 1'b1;
        lock_own_q <= gnt;
      end
      if (m_data_ok & empty)
        err <= 1'b1;
`ifdef ARB_RR_EN
      if (push)
        rr_q <= ~gnt;
`endif
    end
  end

endmodule
